conv_sched: RTL and testbench



---
 rtl/conv_pkg.sv | 18 +
 rtl/conv_pos_cnt.sv | 52 +++++
 rtl/conv_sched.sv | 185 ++++++++++++++++++
 tb/tb_conv_sched.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: constants for the 3-channel 3x3 conv datapath, and the sequencer state encoding.
package conv_pkg;
    localparam int CONV_DW     = 10;                 // signed element width
    localparam int CONV_K      = 9;                  // elements per 3x3 window
    localparam int CONV_BUS_W  = CONV_K * CONV_DW;   // one channel operand bus
    localparam int CONV_CH     = 3;                  // channels per window
    localparam int CONV_DIM_W  = 8;                  // row/col counter width
    localparam int CONV_FILT_W = 6;                  // filter index width

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WREQ = 3'd1,
        S_XREQ = 3'd2,
        S_EXEC = 3'd3,
        S_OUT  = 3'd4,
        S_FIN  = 3'd5
    } sched_state_t;
endpackage

// File: rtl/conv_pos_cnt.sv
// conv_pos_cnt: nested col -> row -> filt position counter with wrap flags and last-position detect.
module conv_pos_cnt import conv_pkg::*; #(
    parameter int DIM_W  = CONV_DIM_W,
    parameter int FILT_W = CONV_FILT_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_adv,
    input  logic [DIM_W-1:0]  i_cfg_h,
    input  logic [DIM_W-1:0]  i_cfg_w,
    input  logic [FILT_W-1:0] i_cfg_nfilt,
    output logic [DIM_W-1:0]  o_row,
    output logic [DIM_W-1:0]  o_col,
    output logic [FILT_W-1:0] o_filt,
    output logic              o_col_wrap,
    output logic              o_row_wrap,
    output logic              o_last
);
    logic filt_wrap;

    // Wrap flags compare against the latched config; a zero config never reaches here.
    assign o_col_wrap = (o_col  == i_cfg_w - DIM_W'(1));
    assign o_row_wrap = (o_row  == i_cfg_h - DIM_W'(1));
    assign filt_wrap  = (o_filt == i_cfg_nfilt - FILT_W'(1));
    assign o_last     = o_col_wrap & o_row_wrap & filt_wrap;

    // Column is the fastest index, filter the slowest; all three return to 0 after the last position.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_row  <= '0;
            o_col  <= '0;
            o_filt <= '0;
        end else if (i_clr) begin
            o_row  <= '0;
            o_col  <= '0;
            o_filt <= '0;
        end else if (i_adv) begin
            if (!o_col_wrap) begin
                o_col <= o_col + DIM_W'(1);
            end else begin
                o_col <= '0;
                if (!o_row_wrap) begin
                    o_row <= o_row + DIM_W'(1);
                end else begin
                    o_row  <= '0;
                    o_filt <= filt_wrap ? '0 : o_filt + FILT_W'(1);
                end
            end
        end
    end
endmodule

// File: rtl/conv_sched.sv
// conv_sched: job sequencer for the 3-channel 3x3 conv datapath (weight fetch, window walk, result stream).
module conv_sched import conv_pkg::*; #(
    parameter int DW       = CONV_DW,
    parameter int K        = CONV_K,
    parameter int DIM_W    = CONV_DIM_W,
    parameter int FILT_W   = CONV_FILT_W,
    parameter int CONV_LAT = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [DIM_W-1:0]      i_cfg_h,
    input  logic [DIM_W-1:0]      i_cfg_w,
    input  logic [FILT_W-1:0]     i_cfg_nfilt,
    input  logic                  i_cfg_opcode,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_wgt_req,
    output logic [FILT_W-1:0]     o_wgt_addr,
    input  logic                  i_wgt_valid,
    input  logic [3*K*DW-1:0]     i_wgt_data,
    output logic                  o_win_req,
    output logic [DIM_W-1:0]      o_win_row,
    output logic [DIM_W-1:0]      o_win_col,
    input  logic                  i_win_valid,
    input  logic [3*K*DW-1:0]     i_win_data,
    output logic [K*DW-1:0]       o_busData0,
    output logic [K*DW-1:0]       o_busData1,
    output logic [K*DW-1:0]       o_busData2,
    output logic [K*DW-1:0]       o_busWeight0,
    output logic [K*DW-1:0]       o_busWeight1,
    output logic [K*DW-1:0]       o_busWeight2,
    output logic                  o_opcode,
    input  logic [DW-1:0]         i_data0,
    input  logic [DW-1:0]         i_data1,
    input  logic [DW-1:0]         i_data2,
    output logic                  o_res_valid,
    input  logic                  i_res_ready,
    output logic [3*DW-1:0]       o_res_data,
    output logic [FILT_W-1:0]     o_res_filt,
    output logic [DIM_W-1:0]      o_res_row,
    output logic [DIM_W-1:0]      o_res_col
);
    localparam int BW = K * DW;
    localparam int CH = CONV_CH;

    typedef struct packed {
        logic [CH-1:0][DW-1:0] data;
        logic [FILT_W-1:0]     filt;
        logic [DIM_W-1:0]      row;
        logic [DIM_W-1:0]      col;
    } res_t;

    sched_state_t state, state_nx;

    logic [DIM_W-1:0]      cfg_h, cfg_w;
    logic [FILT_W-1:0]     cfg_nfilt;
    logic                  cfg_op;
    logic [CH-1:0][BW-1:0] wgt_bus, dat_bus;
    logic [CONV_LAT:0]     vld_pipe;
    res_t                  res_q;

    logic [DIM_W-1:0]  row, col;
    logic [FILT_W-1:0] filt;
    logic              col_wrap, row_wrap, last_pos;
    logic              cnt_clr, cnt_adv;
    logic              cfg_ld, wgt_ld, win_ld, res_ld;
    logic              zero_cfg;

    assign zero_cfg = (i_cfg_h == '0) | (i_cfg_w == '0) | (i_cfg_nfilt == '0);

    conv_pos_cnt #(.DIM_W(DIM_W), .FILT_W(FILT_W)) u_pos (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clr       (cnt_clr),
        .i_adv       (cnt_adv),
        .i_cfg_h     (cfg_h),
        .i_cfg_w     (cfg_w),
        .i_cfg_nfilt (cfg_nfilt),
        .o_row       (row),
        .o_col       (col),
        .o_filt      (filt),
        .o_col_wrap  (col_wrap),
        .o_row_wrap  (row_wrap),
        .o_last      (last_pos)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    // Next state, fetch/stream strobes and counter control; valids only count in their matching state.
    always_comb begin
        state_nx    = state;
        cnt_clr     = 1'b0;
        cnt_adv     = 1'b0;
        cfg_ld      = 1'b0;
        wgt_ld      = 1'b0;
        win_ld      = 1'b0;
        res_ld      = 1'b0;
        o_busy      = (state != S_IDLE);
        o_done      = (state == S_FIN);
        o_wgt_req   = (state == S_WREQ);
        o_win_req   = (state == S_XREQ);
        o_res_valid = (state == S_OUT);
        case (state)
            S_IDLE: if (i_start) begin
                cfg_ld   = 1'b1;
                cnt_clr  = 1'b1;
                state_nx = zero_cfg ? S_FIN : S_WREQ;
            end
            S_WREQ: if (i_wgt_valid) begin
                wgt_ld   = 1'b1;
                state_nx = S_XREQ;
            end
            S_XREQ: if (i_win_valid) begin
                win_ld   = 1'b1;
                state_nx = S_EXEC;
            end
            S_EXEC: if (vld_pipe[CONV_LAT]) begin
                res_ld   = 1'b1;
                state_nx = S_OUT;
            end
            S_OUT: if (i_res_ready) begin
                cnt_adv = 1'b1;
                if (last_pos)                  state_nx = S_FIN;
                else if (col_wrap && row_wrap) state_nx = S_WREQ;
                else                           state_nx = S_XREQ;
            end
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Job config, operand buses and the result register; buses hold between loads so weights span a filter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cfg_h     <= '0;
            cfg_w     <= '0;
            cfg_nfilt <= '0;
            cfg_op    <= 1'b0;
            wgt_bus   <= '0;
            dat_bus   <= '0;
            res_q     <= '0;
        end else begin
            if (cfg_ld) begin
                cfg_h     <= i_cfg_h;
                cfg_w     <= i_cfg_w;
                cfg_nfilt <= i_cfg_nfilt;
                cfg_op    <= i_cfg_opcode;
            end
            if (wgt_ld) wgt_bus <= i_wgt_data;
            if (win_ld) dat_bus <= i_win_data;
            if (res_ld) begin
                res_q.data <= {i_data2, i_data1, i_data0};
                res_q.filt <= filt;
                res_q.row  <= row;
                res_q.col  <= col;
            end
        end
    end

    // Operand-age shift register: bit 0 marks the first EXEC cycle, bit CONV_LAT the sampling cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) vld_pipe <= '0;
        else          vld_pipe <= {vld_pipe[CONV_LAT-1:0], win_ld};
    end

    assign o_wgt_addr   = filt;
    assign o_win_row    = row;
    assign o_win_col    = col;
    assign o_busData0   = dat_bus[0];
    assign o_busData1   = dat_bus[1];
    assign o_busData2   = dat_bus[2];
    assign o_busWeight0 = wgt_bus[0];
    assign o_busWeight1 = wgt_bus[1];
    assign o_busWeight2 = wgt_bus[2];
    assign o_opcode     = cfg_op;
    assign o_res_data   = res_q.data;
    assign o_res_filt   = res_q.filt;
    assign o_res_row    = res_q.row;
    assign o_res_col    = res_q.col;
endmodule

// File: tb/tb_conv_sched.sv
// tb_conv_sched: scoreboard bench for conv_sched with a fetch responder and a behavioural conv model.
module tb_conv_sched;
    localparam int DW = 10, K = 9, BW = K * DW, DIM_W = 8, FILT_W = 6, CONV_LAT = 1;
    localparam int OUTW = 620;

    typedef struct packed {
        logic [3*DW-1:0]   data;
        logic [FILT_W-1:0] filt;
        logic [DIM_W-1:0]  row;
        logic [DIM_W-1:0]  col;
    } exp_t;

    logic clk = 1'b0, rst_n;
    logic i_start, i_cfg_opcode, i_wgt_valid, i_win_valid, i_res_ready;
    logic [DIM_W-1:0] i_cfg_h, i_cfg_w;
    logic [FILT_W-1:0] i_cfg_nfilt;
    logic [3*BW-1:0] i_wgt_data, i_win_data;
    logic [DW-1:0] i_data0, i_data1, i_data2;
    logic o_busy, o_done, o_wgt_req, o_win_req, o_opcode, o_res_valid;
    logic [FILT_W-1:0] o_wgt_addr, o_res_filt;
    logic [DIM_W-1:0] o_win_row, o_win_col, o_res_row, o_res_col;
    logic [BW-1:0] o_busData0, o_busData1, o_busData2, o_busWeight0, o_busWeight1, o_busWeight2;
    logic [3*DW-1:0] o_res_data;

    int checks = 0, failures = 0;
    int cyc = 0, done_cnt = 0, wgt_fetch = 0, req_cyc = 0, res_cnt = 0;
    int mem_lat = 1;
    int win_v[3];
    int wgt_v[4][3];
    logic job_op = 1'b0;
    exp_t sb[$];
    int hs_cyc[$];

    conv_sched #(.CONV_LAT(CONV_LAT)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start),
        .i_cfg_h(i_cfg_h), .i_cfg_w(i_cfg_w), .i_cfg_nfilt(i_cfg_nfilt), .i_cfg_opcode(i_cfg_opcode),
        .o_busy(o_busy), .o_done(o_done),
        .o_wgt_req(o_wgt_req), .o_wgt_addr(o_wgt_addr), .i_wgt_valid(i_wgt_valid), .i_wgt_data(i_wgt_data),
        .o_win_req(o_win_req), .o_win_row(o_win_row), .o_win_col(o_win_col),
        .i_win_valid(i_win_valid), .i_win_data(i_win_data),
        .o_busData0(o_busData0), .o_busData1(o_busData1), .o_busData2(o_busData2),
        .o_busWeight0(o_busWeight0), .o_busWeight1(o_busWeight1), .o_busWeight2(o_busWeight2),
        .o_opcode(o_opcode), .i_data0(i_data0), .i_data1(i_data1), .i_data2(i_data2),
        .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_res_data(o_res_data),
        .o_res_filt(o_res_filt), .o_res_row(o_res_row), .o_res_col(o_res_col)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Conv datapath stand-in: sum of 9 signed products, arithmetic shift right by 10.
    function automatic logic [DW-1:0] conv_ch(input logic [BW-1:0] d, input logic [BW-1:0] w);
        int s;
        s = 0;
        for (int e = 0; e < K; e++) s += int'($signed(d[e*DW +: DW])) * int'($signed(w[e*DW +: DW]));
        return DW'(s >>> 10);
    endfunction

    assign i_data0 = conv_ch(o_busData0, o_busWeight0);
    assign i_data1 = conv_ch(o_busData1, o_busWeight1);
    assign i_data2 = conv_ch(o_busData2, o_busWeight2);

    // Expected channel result for uniform window x and uniform weight w.
    function automatic logic [DW-1:0] exp_ch(input int x, input int w);
        return DW'((9 * x * w) >>> 10);
    endfunction

    function automatic logic [3*BW-1:0] pack(input int c0, input int c1, input int c2);
        logic [3*BW-1:0] b;
        logic [DW-1:0] e;
        for (int ch = 0; ch < 3; ch++) begin
            e = (ch == 0) ? DW'(c0) : (ch == 1) ? DW'(c1) : DW'(c2);
            for (int k = 0; k < K; k++) b[ch*BW + k*DW +: DW] = e;
        end
        return b;
    endfunction

    function automatic logic [OUTW-1:0] all_out();
        return {o_busy, o_done, o_wgt_req, o_wgt_addr, o_win_req, o_win_row, o_win_col,
                o_busData0, o_busData1, o_busData2, o_busWeight0, o_busWeight1, o_busWeight2,
                o_opcode, o_res_valid, o_res_data, o_res_filt, o_res_row, o_res_col};
    endfunction

    // Fetch responder: valid appears mem_lat cycles after a request is first seen.
    initial begin
        int wcnt, xcnt;
        wcnt = 0; xcnt = 0;
        i_wgt_valid = 1'b0; i_win_valid = 1'b0; i_wgt_data = '0; i_win_data = '0;
        forever begin
            @(negedge clk);
            if (o_wgt_req) begin
                i_wgt_valid = (wcnt >= mem_lat);
                i_wgt_data  = pack(wgt_v[o_wgt_addr[1:0]][0], wgt_v[o_wgt_addr[1:0]][1], wgt_v[o_wgt_addr[1:0]][2]);
                wcnt++;
            end else begin
                i_wgt_valid = 1'b0; wcnt = 0;
            end
            if (o_win_req) begin
                i_win_valid = (xcnt >= mem_lat);
                i_win_data  = pack(win_v[0], win_v[1], win_v[2]);
                xcnt++;
            end else begin
                i_win_valid = 1'b0; xcnt = 0;
            end
        end
    end

    // Output monitor: scoreboard compare on every result handshake, plus event counters.
    initial begin
        exp_t e, g;
        forever begin
            @(negedge clk); #1;
            if (o_done) done_cnt++;
            if (o_wgt_req && i_wgt_valid) wgt_fetch++;
            if (o_wgt_req || o_win_req) req_cyc++;
            if (o_res_valid && i_res_ready) begin
                hs_cyc.push_back(cyc);
                res_cnt++;
                g = {o_res_data, o_res_filt, o_res_row, o_res_col};
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_result: got %h, expected no result", g);
                end else begin
                    e = sb.pop_front();
                    if (g !== e) begin
                        failures++;
                        $display("FAIL result: got data=%h f=%0d r=%0d c=%0d, want data=%h f=%0d r=%0d c=%0d",
                                 g.data, g.filt, g.row, g.col, e.data, e.filt, e.row, e.col);
                    end
                end
                checks++;
                if (o_opcode !== job_op) begin
                    failures++;
                    $display("FAIL opcode: got %b want %b", o_opcode, job_op);
                end
            end
        end
    end

    task automatic push_exp(input int h, input int w, input int nf);
        for (int f = 0; f < nf; f++)
            for (int r = 0; r < h; r++)
                for (int c = 0; c < w; c++)
                    sb.push_back({exp_ch(win_v[2], wgt_v[f][2]), exp_ch(win_v[1], wgt_v[f][1]),
                                  exp_ch(win_v[0], wgt_v[f][0]), FILT_W'(f), DIM_W'(r), DIM_W'(c)});
    endtask

    // Runs one job to o_done; with inject set, pulses a conflicting i_start after the first result.
    task automatic run_job(input int h, input int w, input int nf, input logic op, input bit inject, input string nm);
        int wf0, d0, r0;
        bit seen, injected;
        push_exp(h, w, nf);
        job_op = op;
        wf0 = wgt_fetch; d0 = done_cnt; r0 = res_cnt;
        @(negedge clk);
        i_cfg_h = DIM_W'(h); i_cfg_w = DIM_W'(w); i_cfg_nfilt = FILT_W'(nf); i_cfg_opcode = op; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        seen = 0; injected = 0;
        for (int i = 0; i < 4000 && !seen; i++) begin
            @(negedge clk);
            i_start = 1'b0;
            #1;
            if (o_done) seen = 1;
            if (inject && !injected && res_cnt > r0) begin
                i_cfg_h = 8'd5; i_cfg_w = 8'd5; i_cfg_nfilt = 6'd3; i_cfg_opcode = ~op; i_start = 1'b1;
                injected = 1;
            end
        end
        @(negedge clk); #1;
        checks++;
        if (!seen) begin failures++; $display("FAIL %s_timeout: o_done not seen, want within 4000 cycles", nm); end
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL %s_missing: %0d results outstanding, want 0", nm, sb.size()); end
        checks++;
        if (done_cnt - d0 != 1) begin failures++; $display("FAIL %s_done_count: got %0d want 1", nm, done_cnt - d0); end
        checks++;
        if (wgt_fetch - wf0 != nf) begin failures++; $display("FAIL %s_wgt_fetches: got %0d want %0d", nm, wgt_fetch - wf0, nf); end
        checks++;
        if (o_busy !== 1'b0) begin failures++; $display("FAIL %s_busy_after: got %b want 0", nm, o_busy); end
    endtask

    task automatic set_uniform(input int x, input int w0, input int w1);
        win_v = '{x, x, x};
        wgt_v[0] = '{w0, w0, w0};
        wgt_v[1] = '{w1, w1, w1};
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (all_out() !== '0) begin failures++; $display("FAIL reset_outputs: got %h want 0", all_out()); end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (all_out() !== '0) begin failures++; $display("FAIL idle_outputs: got %h want 0", all_out()); end
    endtask

    task automatic test_single();
        mem_lat = 1;
        set_uniform(100, 50, 50);                // 9*100*50 = 45000 >>> 10 = 43
        run_job(1, 1, 1, 1'b1, 0, "single");
    endtask

    task automatic test_multi();
        mem_lat = 1;
        set_uniform(200, 50, 60);                // 90000>>>10 = 87, 108000>>>10 = 105
        run_job(2, 2, 2, 1'b0, 0, "multi");
    endtask

    task automatic test_negative();
        mem_lat = 1;
        set_uniform(-100, 50, 50);               // -45000 >>> 10 = -44
        run_job(1, 1, 1, 1'b1, 0, "neg_a");
        set_uniform(-150, 100, 100);             // -135000 >>> 10 = -132
        run_job(1, 1, 1, 1'b1, 0, "neg_b");
        win_v = '{-100, -150, 200};              // per channel: -44, -132, 105
        wgt_v[0] = '{50, 100, 60};
        run_job(1, 1, 1, 1'b0, 0, "neg_mix");
    endtask

    task automatic test_backpressure();
        bit got;
        mem_lat = 1;
        set_uniform(30, 20, 20);
        i_res_ready = 1'b0;
        push_exp(1, 2, 1);
        job_op = 1'b1;
        @(negedge clk);
        i_cfg_h = 8'd1; i_cfg_w = 8'd2; i_cfg_nfilt = 6'd1; i_cfg_opcode = 1'b1; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk); #1;
            if (o_res_valid) got = 1;
        end
        checks++;
        if (!got) begin failures++; $display("FAIL bp_valid_timeout: o_res_valid not seen, want within 100 cycles"); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            checks++;
            if (o_res_valid !== 1'b1 || o_win_req !== 1'b0 || {o_res_data, o_res_filt, o_res_row, o_res_col} !== sb[0]) begin
                failures++;
                $display("FAIL bp_hold[%0d]: valid=%b winreq=%b res=%h, want valid=1 winreq=0 res=%h",
                         i, o_res_valid, o_win_req, {o_res_data, o_res_filt, o_res_row, o_res_col}, sb[0]);
            end
        end
        @(negedge clk);
        i_res_ready = 1'b1;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk); #1;
            if (o_done) got = 1;
        end
        @(negedge clk); #1;
        checks++;
        if (!got || sb.size() != 0) begin
            failures++;
            $display("FAIL bp_finish: done=%b outstanding=%0d, want done=1 outstanding=0", got, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        mem_lat = 0;
        set_uniform(7, 9, 9);
        hs_cyc.delete();
        run_job(1, 3, 1, 1'b0, 0, "b2b");
        checks++;
        if (hs_cyc.size() != 3) begin
            failures++; $display("FAIL b2b_count: got %0d handshakes want 3", hs_cyc.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (hs_cyc[i] - hs_cyc[i-1] != 3 + CONV_LAT) begin
                    failures++;
                    $display("FAIL b2b_gap[%0d]: got %0d cycles want %0d", i, hs_cyc[i] - hs_cyc[i-1], 3 + CONV_LAT);
                end
            end
        end
        mem_lat = 1;
    endtask

    task automatic test_zero_cfg();
        int rq0, d0, r0;
        rq0 = req_cyc; d0 = done_cnt; r0 = res_cnt;
        @(negedge clk);
        i_cfg_h = 8'd3; i_cfg_w = 8'd0; i_cfg_nfilt = 6'd2; i_cfg_opcode = 1'b1; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        #1;
        checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b1) begin
            failures++; $display("FAIL zero_done_pulse: done=%b busy=%b want 1 1", o_done, o_busy);
        end
        @(negedge clk); #1;
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            failures++; $display("FAIL zero_after: done=%b busy=%b want 0 0", o_done, o_busy);
        end
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if (req_cyc != rq0 || res_cnt != r0 || done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL zero_activity: req_cycles=%0d results=%0d dones=%0d want 0 0 1", req_cyc - rq0, res_cnt - r0, done_cnt - d0);
        end
    endtask

    task automatic test_start_ignored();
        int r0;
        mem_lat = 1;
        set_uniform(40, 30, 30);
        r0 = res_cnt;
        run_job(3, 1, 1, 1'b1, 1, "start_busy");
        checks++;
        if (res_cnt - r0 != 3) begin failures++; $display("FAIL start_busy_results: got %0d want 3", res_cnt - r0); end
    endtask

    task automatic test_reset_mid();
        bit got;
        int d0;
        mem_lat = 1;
        set_uniform(50, 40, 40);
        i_res_ready = 1'b0;
        push_exp(1, 2, 1);
        job_op = 1'b1;
        @(negedge clk);
        i_cfg_h = 8'd1; i_cfg_w = 8'd2; i_cfg_nfilt = 6'd1; i_cfg_opcode = 1'b1; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk); #1;
            if (o_res_valid) got = 1;
        end
        checks++;
        if (!got) begin failures++; $display("FAIL rstmid_valid_timeout: o_res_valid not seen, want within 100 cycles"); end
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (all_out() !== '0) begin failures++; $display("FAIL rstmid_outputs: got %h want 0", all_out()); end
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        i_res_ready = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        checks++;
        if (done_cnt != d0) begin failures++; $display("FAIL rstmid_no_done: got %0d dones want 0", done_cnt - d0); end
        wgt_v[0] = '{-20, -20, -20};             // 9*50*-20 = -9000 >>> 10 = -9
        run_job(1, 1, 1, 1'b0, 0, "rstmid_rerun");
    endtask

    initial begin
        rst_n = 1'b0; i_start = 1'b0; i_cfg_h = '0; i_cfg_w = '0; i_cfg_nfilt = '0; i_cfg_opcode = 1'b0;
        i_res_ready = 1'b1;
        win_v = '{0, 0, 0};
        for (int f = 0; f < 4; f++) wgt_v[f] = '{0, 0, 0};
        test_reset();
        test_single();
        test_multi();
        test_negative();
        test_backpressure();
        test_back_to_back();
        test_zero_cfg();
        test_start_ignored();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
